// File: rtl/sbox_lut_mc_pkg.sv
// Shared constants and types for the multi-channel S-box lookup block.
package sbox_lut_mc_pkg;
  localparam int   SBOX_ENTRIES = 256;
  localparam logic SBOX_SEL_FWD = 1'b0;
  localparam logic SBOX_SEL_INV = 1'b1;

  typedef enum logic {LD_IDLE, LD_LOAD} ld_state_t;

  // Index width that stays legal when only one beat/entry exists.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sbox_table_ram.sv
// One 256x8 substitution table: beat-wide write port, many combinational read ports.
module sbox_table_ram
  import sbox_lut_mc_pkg::*;
#(
  parameter int LOAD_BYTES = 4,
  parameter int NUM_RD     = 8,
  parameter int BW         = idx_w(SBOX_ENTRIES / LOAD_BYTES)
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [BW-1:0]                 wr_beat,
  input  logic [8*LOAD_BYTES-1:0]       wr_data,
  input  logic [NUM_RD-1:0][7:0]        rd_addr,
  output logic [NUM_RD-1:0][7:0]        rd_data
);
  // Contents are intentionally not reset; the ready bits in the top gate use.
  logic [7:0] mem [SBOX_ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < LOAD_BYTES; j++)
        mem[8'(int'(wr_beat) * LOAD_BYTES + j)] <= wr_data[8*j +: 8];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_data[i] = mem[rd_addr[i]];
  end
endmodule

// File: rtl/sbox_lut_mc.sv
// Forward/inverse S-box lookup shared by NUM_CH independent handshaked channels,
// with a beat-serial table loader.
module sbox_lut_mc
  import sbox_lut_mc_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int BYTES_PER_WORD = 4,
  parameter int LOAD_BYTES     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tbl_wr_vld,
  input  logic                             tbl_wr_sel,
  input  logic [8*LOAD_BYTES-1:0]          tbl_wr_data,
  output logic                             tbl_busy,
  output logic [1:0]                       tbl_ready,
  input  logic [NUM_CH-1:0]                req_vld,
  input  logic [NUM_CH-1:0]                req_inv,
  input  logic [NUM_CH*8*BYTES_PER_WORD-1:0] req_data,
  output logic [NUM_CH-1:0]                req_rdy,
  output logic [NUM_CH-1:0]                resp_vld,
  output logic [NUM_CH*8*BYTES_PER_WORD-1:0] resp_data,
  input  logic [NUM_CH-1:0]                resp_rdy
);
  localparam int WW  = 8 * BYTES_PER_WORD;
  localparam int NB  = SBOX_ENTRIES / LOAD_BYTES;
  localparam int CW  = idx_w(NB);
  localparam int NRD = NUM_CH * BYTES_PER_WORD;

  ld_state_t       state;
  logic [CW-1:0]   beat_cnt;
  logic            cur_sel;
  logic            wr_sel;
  logic [CW-1:0]   wr_beat;
  logic            last_beat;

  // The first beat is taken in IDLE, so select and index come from the port there.
  assign wr_sel    = (state == LD_IDLE) ? tbl_wr_sel : cur_sel;
  assign wr_beat   = (state == LD_IDLE) ? '0 : beat_cnt;
  assign last_beat = (wr_beat == CW'(NB - 1));
  assign tbl_busy  = (state == LD_LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LD_IDLE;
      beat_cnt  <= '0;
      cur_sel   <= SBOX_SEL_FWD;
      tbl_ready <= '0;
    end else if (tbl_wr_vld) begin
      if (state == LD_IDLE) cur_sel <= tbl_wr_sel;
      if (last_beat) begin
        state             <= LD_IDLE;
        beat_cnt          <= '0;
        tbl_ready[wr_sel] <= 1'b1;
      end else begin
        state             <= LD_LOAD;
        beat_cnt          <= wr_beat + 1'b1;
        tbl_ready[wr_sel] <= 1'b0;
      end
    end
  end

  logic [NRD-1:0][7:0]       rd_addr, fwd_rd, inv_rd;
  logic [NUM_CH-1:0][WW-1:0] fwd_w, inv_w, resp_q;

  assign rd_addr = req_data;

  sbox_table_ram #(.LOAD_BYTES(LOAD_BYTES), .NUM_RD(NRD), .BW(CW)) u_fwd (
    .clk     (clk),
    .wr_en   (tbl_wr_vld && wr_sel == SBOX_SEL_FWD),
    .wr_beat (wr_beat),
    .wr_data (tbl_wr_data),
    .rd_addr (rd_addr),
    .rd_data (fwd_rd)
  );

  sbox_table_ram #(.LOAD_BYTES(LOAD_BYTES), .NUM_RD(NRD), .BW(CW)) u_inv (
    .clk     (clk),
    .wr_en   (tbl_wr_vld && wr_sel == SBOX_SEL_INV),
    .wr_beat (wr_beat),
    .wr_data (tbl_wr_data),
    .rd_addr (rd_addr),
    .rd_data (inv_rd)
  );

  assign fwd_w     = fwd_rd;
  assign inv_w     = inv_rd;
  assign resp_data = resp_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_rdy
    assign req_rdy[c] = tbl_ready[req_inv[c]] & (~resp_vld[c] | resp_rdy[c]);
  end

  // Response stage: load on accept, otherwise drop valid once consumed; data holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_vld <= '0;
      resp_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_vld[c] && req_rdy[c]) begin
          resp_vld[c] <= 1'b1;
          resp_q[c]   <= req_inv[c] ? inv_w[c] : fwd_w[c];
        end else if (resp_rdy[c]) begin
          resp_vld[c] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sbox_lut_mc.sv
// Bench for sbox_lut_mc: directed vectors, corner sequences and a random run
// against a table-level model of the lookup channels.
module tb_sbox_lut_mc;
  localparam int NUM_CH = 2;
  localparam int BPW    = 4;
  localparam int LB     = 4;
  localparam int WW     = 8 * BPW;
  localparam int NB     = 256 / LB;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   tbl_wr_vld = 1'b0;
  logic                   tbl_wr_sel = 1'b0;
  logic [8*LB-1:0]        tbl_wr_data = '0;
  logic                   tbl_busy;
  logic [1:0]             tbl_ready;
  logic [NUM_CH-1:0]      req_vld = '0;
  logic [NUM_CH-1:0]      req_inv = '0;
  logic [NUM_CH*WW-1:0]   req_data = '0;
  logic [NUM_CH-1:0]      req_rdy;
  logic [NUM_CH-1:0]      resp_vld;
  logic [NUM_CH*WW-1:0]   resp_data;
  logic [NUM_CH-1:0]      resp_rdy = '0;

  always #5 clk = ~clk;

  sbox_lut_mc #(.NUM_CH(NUM_CH), .BYTES_PER_WORD(BPW), .LOAD_BYTES(LB)) dut (
    .clk(clk), .reset(reset),
    .tbl_wr_vld(tbl_wr_vld), .tbl_wr_sel(tbl_wr_sel), .tbl_wr_data(tbl_wr_data),
    .tbl_busy(tbl_busy), .tbl_ready(tbl_ready),
    .req_vld(req_vld), .req_inv(req_inv), .req_data(req_data), .req_rdy(req_rdy),
    .resp_vld(resp_vld), .resp_data(resp_data), .resp_rdy(resp_rdy)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]    aes_s [256];
  logic [7:0]    aes_i [256];
  logic [7:0]    fwd_m [256];
  logic [7:0]    inv_m [256];
  logic [7:0]    img   [256];
  bit            m_ready [2];
  bit            m_vld   [NUM_CH];
  logic [WW-1:0] m_data  [NUM_CH];
  logic [7:0]    ab, as;

  typedef struct {
    bit          inv0;
    logic [31:0] d0;
    bit          inv1;
    logic [31:0] d1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [15:0] t;
    t = {v, v} >> (8 - k);
    return t[7:0];
  endfunction

  function automatic logic [WW-1:0] lk(input bit inv, input logic [WW-1:0] w);
    logic [WW-1:0] r;
    for (int j = 0; j < BPW; j++)
      r[8*j +: 8] = inv ? inv_m[w[8*j +: 8]] : fwd_m[w[8*j +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ready[0] = 1'b0;
    m_ready[1] = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_vld[c]  = 1'b0;
      m_data[c] = '0;
    end
  endtask

  // One lookup cycle with the currently driven inputs; checks handshake and response.
  task automatic chan_cycle();
    bit            acc [NUM_CH];
    logic [WW-1:0] nd  [NUM_CH];
    bit            er;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      er     = m_ready[req_inv[c]] && (!m_vld[c] || resp_rdy[c]);
      check($sformatf("req_rdy ch%0d", c), req_rdy[c], er);
      acc[c] = req_vld[c] && er;
      nd[c]  = lk(req_inv[c], req_data[c*WW +: WW]);
    end
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      if (acc[c]) begin
        m_vld[c]  = 1'b1;
        m_data[c] = nd[c];
      end else if (resp_rdy[c]) begin
        m_vld[c] = 1'b0;
      end
      check($sformatf("resp_vld ch%0d", c), resp_vld[c], m_vld[c]);
      check($sformatf("resp_data ch%0d", c), resp_data[c*WW +: WW], m_data[c]);
    end
  endtask

  // Streams img into table sel; gap cycle before every gap_every-th beat; abort_at>=0 pulls reset there.
  task automatic load_table(input bit sel, input int gap_every, input int abort_at);
    for (int b = 0; b < NB; b++) begin
      if (b == abort_at) begin
        tbl_wr_vld = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        check("abort tbl_ready", tbl_ready, 2'b00);
        check("abort tbl_busy", tbl_busy, 1'b0);
        check("abort resp_vld", resp_vld, '0);
        tick();
        reset = 1'b1;
        return;
      end
      if (gap_every > 0 && b > 0 && (b % gap_every) == 0) begin
        tbl_wr_vld = 1'b0;
        tick();
        check("tbl_busy gap", tbl_busy, 1'b1);
      end
      tbl_wr_vld = 1'b1;
      tbl_wr_sel = (b == 0) ? sel : ~sel;
      for (int j = 0; j < LB; j++) tbl_wr_data[8*j +: 8] = img[b*LB + j];
      tick();
      if (b == 0) m_ready[sel] = 1'b0;
      if (b == NB - 1) begin
        for (int e = 0; e < 256; e++) begin
          if (sel) inv_m[e] = img[e];
          else     fwd_m[e] = img[e];
        end
        m_ready[sel] = 1'b1;
      end
      check("tbl_busy load", tbl_busy, b != NB - 1);
    end
    tbl_wr_vld = 1'b0;
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      ab = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) ab = 8'(y);
      as = ab ^ rotl(ab, 1) ^ rotl(ab, 2) ^ rotl(ab, 3) ^ rotl(ab, 4) ^ 8'h63;
      aes_s[x]  = as;
      aes_i[as] = 8'(x);
    end
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset tbl_ready", tbl_ready, 2'b00);
    check("reset tbl_busy", tbl_busy, 1'b0);
    check("reset resp_vld", resp_vld, '0);
    check("reset resp_data", resp_data, '0);
    reset = 1'b1;
    tick();

    // Nothing loaded: both tables refused.
    resp_rdy = 2'b11;
    req_vld = 2'b11; req_inv = 2'b10; req_data = {$urandom, $urandom};
    chan_cycle();
    req_inv = 2'b01;
    chan_cycle();
    req_vld = '0;

    for (int e = 0; e < 256; e++) img[e] = aes_s[e];
    load_table(1'b0, 20, -1);
    check("tbl_ready fwd only", tbl_ready, 2'b01);

    req_vld = 2'b11; req_inv = 2'b11;
    chan_cycle();

    req_vld = 2'b01; req_inv = 2'b00; req_data[31:0] = 32'h00112233;
    chan_cycle();
    check("first fwd lookup", resp_data[31:0], 32'h638293C3);
    req_vld = '0;
    chan_cycle();

    for (int e = 0; e < 256; e++) img[e] = aes_i[e];
    load_table(1'b1, 0, -1);
    check("tbl_ready both", tbl_ready, 2'b11);

    vecs[0] = '{1'b1, 32'h63C27C7C, 1'b0, 32'h00000053, 32'h00A80101, 32'h636363ED};
    vecs[1] = '{1'b0, 32'h00112233, 1'b1, 32'h63636363, 32'h638293C3, 32'h00000000};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 1'b1, 32'h16161616, 32'h16161616, 32'hFFFFFFFF};
    vecs[3] = '{1'b1, 32'h00000000, 1'b0, 32'h0000FF01, 32'h52525252, 32'h6363167C};
    for (int v = 0; v < 4; v++) begin
      req_vld = 2'b11;
      req_inv = {vecs[v].inv1, vecs[v].inv0};
      req_data = {vecs[v].d1, vecs[v].d0};
      chan_cycle();
      check($sformatf("vec%0d resp_vld", v), resp_vld, 2'b11);
      check($sformatf("vec%0d ch0", v), resp_data[31:0], vecs[v].e0);
      check($sformatf("vec%0d ch1", v), resp_data[63:32], vecs[v].e1);
    end
    req_vld = '0;
    chan_cycle();

    // Backpressure on ch1 with a second request waiting.
    resp_rdy = 2'b01;
    req_vld = 2'b10; req_inv = 2'b00; req_data[63:32] = 32'h00112233;
    chan_cycle();
    req_data[63:32] = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      chan_cycle();
      check("bp held data", resp_data[63:32], 32'h638293C3);
    end
    resp_rdy = 2'b11;
    chan_cycle();
    check("bp released data", resp_data[63:32], 32'h16161616);
    req_vld = '0;
    chan_cycle();

    // Reload forward with 0xFF while ch0 streams inverse lookups and ch1 hammers forward.
    for (int e = 0; e < 256; e++) img[e] = 8'hFF;
    fork
      load_table(1'b0, 0, -1);
      begin
        for (int i = 0; i <= NB + 1; i++) begin
          req_vld = 2'b11; req_inv = 2'b01;
          req_data = {32'h12345678, $urandom};
          chan_cycle();
        end
        req_vld = '0;
      end
    join
    check("reload fwd result", resp_data[63:32], 32'hFFFFFFFF);
    check("tbl_ready after reload", tbl_ready, 2'b11);

    // Park a response, then reset in the middle of a load.
    resp_rdy = 2'b00;
    req_vld = 2'b01; req_inv = 2'b01; req_data[31:0] = 32'h63C27C7C;
    chan_cycle();
    req_vld = '0;
    chan_cycle();
    for (int e = 0; e < 256; e++) img[e] = aes_s[e];
    load_table(1'b0, 0, 30);
    req_vld = 2'b11; req_inv = 2'b10;
    chan_cycle();
    check("post-abort tbl_busy", tbl_busy, 1'b0);

    load_table(1'b0, 0, -1);
    for (int e = 0; e < 256; e++) img[e] = aes_i[e];
    load_table(1'b1, 7, -1);
    check("tbl_ready restored", tbl_ready, 2'b11);

    for (int n = 0; n < 400; n++) begin
      req_vld  = 2'($urandom);
      req_inv  = 2'($urandom);
      req_data = {$urandom, $urandom};
      for (int c = 0; c < NUM_CH; c++) resp_rdy[c] = ($urandom_range(0, 3) != 0);
      chan_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
